// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator.
//   Input side : in_valid/in_ready carry one 9-bit sample {in_carry, in_data}.
//   Output side: out_valid/out_ready carry one block result {out_sum, out_count, out_ovf}.
// Handshake rule (both sides): a transfer happens on a rising clk edge where valid and ready
// are both high; the source holds valid and its payload stable until that edge, and ready is
// never a combinational function of valid.
// Modports: master = upstream producer / downstream consumer side, slave = the accumulator.
interface sum_accumulator_if #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int COUNT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               in_carry;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [COUNT_W-1:0] out_count;
  logic               out_ovf;

  modport master (
    output in_valid, in_data, in_carry, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_carry, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates blocks of 9-bit adder sums ({carry, byte}) and presents the
// block total, sample count and an overflow flag on a registered valid/ready output.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clear      synchronous abort of the partial block and any held result
//   block_len  samples per block, sampled on the first accept of a block (0 acts as 1)
//   bus        sum_accumulator_if.slave: in_valid/in_ready/in_data/in_carry,
//              out_valid/out_ready/out_sum/out_count/out_ovf
//   state_dbg  current FSM state (0 = ACCUM, 1 = HOLD)
module sum_accumulator #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int COUNT_W  = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [COUNT_W-1:0] block_len,
  sum_accumulator_if.slave   bus,
  output logic               state_dbg
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] len_q;
  logic               ovf;

  logic [ACC_W-1:0]   sample;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   acc_next;
  logic               ovf_next;
  logic [COUNT_W-1:0] eff_len;
  logic [COUNT_W-1:0] cnt_inc;
  logic               ready;
  logic               accept;

  assign sample   = ACC_W'({bus.in_carry, bus.in_data});
  assign sum_wide = {1'b0, acc} + {1'b0, sample};
  // Saturated acc is all-ones, so any further non-zero sample overflows again and it stays put.
  assign acc_next = sum_wide[ACC_W] ? (SATURATE ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0])
                                    : sum_wide[ACC_W-1:0];
  assign ovf_next = ovf | sum_wide[ACC_W];
  // On the first sample of a block the live block_len is used; afterwards the latched copy.
  assign eff_len  = (cnt == '0) ? ((block_len == '0) ? COUNT_W'(1) : block_len) : len_q;
  assign cnt_inc  = cnt + COUNT_W'(1);

  // Ready depends only on state, rst and clear -- never on in_valid.
  assign ready        = (state == ACCUM) && !rst && !clear;
  assign accept       = bus.in_valid && ready;
  assign bus.in_ready = ready;
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      len_q         <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (clear) begin
      // Result registers keep their last values; only the valid and the partial block go.
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (cnt == '0) len_q <= eff_len;
            acc <= acc_next;
            ovf <= ovf_next;
            cnt <= cnt_inc;
            if (cnt_inc == eff_len) begin
              bus.out_sum   <= acc_next;
              bus.out_count <= cnt_inc;
              bus.out_ovf   <= ovf_next;
              bus.out_valid <= 1'b1;
              state         <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances share one stimulus stream (16-bit saturating,
// 10-bit saturating, 10-bit wrapping). A block-level reference model keeps the plain integer
// total of each block and derives each configuration's result from it.
module tb_sum_accumulator;

  localparam int DATA_W  = 8;
  localparam int COUNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [COUNT_W-1:0] block_len;
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_carry;
  logic out_ready;
  logic dbg0, dbg1, dbg2;

  always #5 clk = ~clk;

  sum_accumulator_if #(.DATA_W(DATA_W), .ACC_W(16), .COUNT_W(COUNT_W)) ifa ();
  sum_accumulator_if #(.DATA_W(DATA_W), .ACC_W(10), .COUNT_W(COUNT_W)) ifb ();
  sum_accumulator_if #(.DATA_W(DATA_W), .ACC_W(10), .COUNT_W(COUNT_W)) ifc ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;  assign ifc.in_valid = in_valid;
  assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;   assign ifc.in_data  = in_data;
  assign ifa.in_carry = in_carry;  assign ifb.in_carry = in_carry;  assign ifc.in_carry = in_carry;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(16), .COUNT_W(COUNT_W), .SATURATE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .block_len(block_len), .bus(ifa.slave), .state_dbg(dbg0));
  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(10), .COUNT_W(COUNT_W), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .block_len(block_len), .bus(ifb.slave), .state_dbg(dbg1));
  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(10), .COUNT_W(COUNT_W), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .block_len(block_len), .bus(ifc.slave), .state_dbg(dbg2));

  // Per-instance views of the outputs, indexed 0..2.
  logic        act_valid[3];
  logic        act_ready[3];
  logic [15:0] act_sum[3];
  logic [3:0]  act_cnt[3];
  logic        act_ovf[3];
  assign act_valid[0] = ifa.out_valid; assign act_valid[1] = ifb.out_valid; assign act_valid[2] = ifc.out_valid;
  assign act_ready[0] = ifa.in_ready;  assign act_ready[1] = ifb.in_ready;  assign act_ready[2] = ifc.in_ready;
  assign act_sum[0] = ifa.out_sum;     assign act_sum[1] = 16'(ifb.out_sum); assign act_sum[2] = 16'(ifc.out_sum);
  assign act_cnt[0] = ifa.out_count;   assign act_cnt[1] = ifb.out_count;   assign act_cnt[2] = ifc.out_count;
  assign act_ovf[0] = ifa.out_ovf;     assign act_ovf[1] = ifb.out_ovf;     assign act_ovf[2] = ifc.out_ovf;

  int cfg_w[3]   = '{16, 10, 10};
  bit cfg_sat[3] = '{1'b1, 1'b1, 1'b0};

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", name, k, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Each entry packs three results: per instance {sum[15:0], count[3:0], ovf} (21 bits).
  logic [62:0] exp_q[$];
  int          m_total;
  int          m_cnt;
  int          m_len;
  bit          m_hold;
  int          m_sum[3];
  int          m_count;
  bit          m_ovf[3];

  function automatic void ref_result(input int total, input int w, input bit sat,
                                     output int s, output bit o);
    int lim;
    lim = 1 << w;
    o = (total >= lim);
    s = o ? (sat ? lim - 1 : total % lim) : total;
  endfunction

  initial begin
    m_total = 0; m_cnt = 0; m_len = 1; m_hold = 1'b0; m_count = 0;
    for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_ovf[k] = 1'b0; end
  end

  always @(posedge clk) begin
    if (rst || clear) begin
      if (m_hold && exp_q.size() > 0) void'(exp_q.pop_back());
      m_hold = 1'b0; m_cnt = 0; m_total = 0;
      if (rst) begin
        m_count = 0;
        for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_ovf[k] = 1'b0; end
      end
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 1'b0; m_cnt = 0; m_total = 0; end
    end else if (in_valid) begin
      logic [62:0] e;
      if (m_cnt == 0) m_len = (block_len == 0) ? 1 : int'(block_len);
      m_total += int'({in_carry, in_data});
      m_cnt++;
      if (m_cnt == m_len) begin
        m_count = m_cnt;
        for (int k = 0; k < 3; k++) begin
          ref_result(m_total, cfg_w[k], cfg_sat[k], m_sum[k], m_ovf[k]);
          e[k*21 +: 21] = {16'(m_sum[k]), 4'(m_count), m_ovf[k]};
        end
        exp_q.push_back(e);
        m_hold = 1'b1;
      end
    end
  end

  // ---------------- per-cycle checks and result monitor ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        check("in_ready",  k, 32'(act_ready[k]), 32'(!rst && !clear && !m_hold));
        check("out_valid", k, 32'(act_valid[k]), 32'(m_hold));
        check("out_sum",   k, 32'(act_sum[k]),   32'(m_sum[k]));
        check("out_count", k, 32'(act_cnt[k]),   32'(m_count));
        check("out_ovf",   k, 32'(act_ovf[k]),   32'(m_ovf[k]));
      end
      // A result is delivered on the coming edge: pop and compare it.
      if (act_valid[0] && out_ready && !rst && !clear) begin
        check("result_pending", 0, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [62:0] e;
          e = exp_q.pop_front();
          for (int k = 0; k < 3; k++) begin
            check("deliv_sum",   k, 32'(act_sum[k]), 32'(e[k*21+5 +: 16]));
            check("deliv_count", k, 32'(act_cnt[k]), 32'(e[k*21+1 +: 4]));
            check("deliv_ovf",   k, 32'(act_ovf[k]), 32'(e[k*21]));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [8:0] s);
    bit go;
    in_valid = 1'b1;
    {in_carry, in_data} = s;
    for (int i = 0; i < 100; i++) begin
      go = ifa.in_ready;
      cycle();
      if (go) begin
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout @%0t: in_ready stayed 0 for 100 cycles", $time);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; block_len = 4'd3;
    in_valid = 1'b0; in_data = '0; in_carry = 1'b0; out_ready = 1'b1;
    cycle();
    checking = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // basic block of three
    block_len = 4'd3;
    send(9'd10); send(9'd20); send(9'd30);
    idle(3);

    // carry-in samples
    block_len = 4'd2;
    send(9'h1FF); send(9'h1FF);
    idle(2);

    // overflow: saturates / wraps in the 10-bit instances
    block_len = 4'd3;
    send(9'h1FF); send(9'h1FF); send(9'h1FF);
    idle(2);

    // backpressure while upstream keeps offering a sample
    block_len = 4'd2;
    out_ready = 1'b0;
    send(9'd5); send(9'd7);
    in_valid = 1'b1; {in_carry, in_data} = 9'd9;
    idle(5);
    out_ready = 1'b1;
    send(9'd9); send(9'd11);
    idle(3);

    // block_len = 0 acts as one; mid-block length change ignored
    block_len = 4'd0;
    send(9'd1); send(9'd2); send(9'd3);
    block_len = 4'd3;
    send(9'd4);
    block_len = 4'd5;
    send(9'd5); send(9'd6);
    idle(3);

    // clear part way through, then a fresh block of ones
    block_len = 4'd4;
    send(9'd100); send(9'd50);
    clear = 1'b1; cycle(); clear = 1'b0;
    send(9'd1); send(9'd1); send(9'd1); send(9'd1);
    idle(3);

    // reset while a result is held and out_ready is high
    block_len = 4'd2;
    out_ready = 1'b0;
    send(9'd3); send(9'd4);
    cycle();
    rst = 1'b1; out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    idle(3);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      {in_carry, in_data} = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 4) == 0) {in_carry, in_data} = 9'h1FF;
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) block_len = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(5);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
